// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared defaults and helpers for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_BURST_MAX = 8;
  localparam int DEF_CNT_W     = 16;

  // Bits needed to hold a counter that runs from 0 up to max_val inclusive.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - external requester (debug loader / DMA) port of the arbiter
interface dmem_arbiter_if;

  logic        req;
  logic        we;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        valid;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rdata, valid
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rdata, valid
  );

endinterface

// File: rtl/dmem_arbiter_register.sv
// rtl/dmem_arbiter_register.sv - enabled register with synchronous active-high clear
module dmem_arbiter_register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority single-port data-memory arbiter with bounded
// external starvation and capped locked bursts
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_read,
  input  logic             cpu_write,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  dmem_arbiter_if.slave    ext,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WW = cnt_bits(MAX_WAIT);
  localparam int BW = cnt_bits(BURST_MAX);
  localparam logic [WW-1:0] WAIT_TOP  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_TOP = BW'(BURST_MAX);

  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_acc;
  logic          forced;
  logic          burst_ok;
  logic          gnt;
  logic          rd_gnt;
  logic [31:0]   rdata_q;
  logic          valid_q;

  assign cpu_acc   = cpu_read | cpu_write;
  assign forced    = ext.req & (wait_cnt == WAIT_TOP);
  assign burst_ok  = burst_cnt < BURST_TOP;
  assign gnt       = ext.req & burst_ok & (~cpu_acc | forced);
  assign rd_gnt    = gnt & ~ext.we;
  assign cpu_stall = cpu_acc & gnt;

  assign mem_addr  = gnt ? ext.addr  : cpu_addr;
  assign mem_wdata = gnt ? ext.wdata : cpu_wdata;
  assign mem_read  = gnt ? ~ext.we   : cpu_read;
  assign mem_write = gnt ? ext.we    : cpu_write;
  assign cpu_rdata = mem_rdata;

  assign ext.gnt   = gnt;
  assign ext.rdata = rdata_q;
  assign ext.valid = valid_q;

  // A burst that has used up its budget forfeits one cycle to the CPU and restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      burst_cnt   <= '0;
      stall_count <= '0;
    end else begin
      if (gnt || !ext.req)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_TOP)
        wait_cnt <= wait_cnt + 1'b1;

      if (!ext.req || !burst_ok)
        burst_cnt <= '0;
      else if (gnt)
        burst_cnt <= ext.lock ? burst_cnt + 1'b1 : '0;

      if (cpu_stall && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  dmem_arbiter_register #(.W(32)) u_rdata_reg (
    .clk   (clk),
    .reset (reset),
    .en    (rd_gnt),
    .d     (mem_rdata),
    .q     (rdata_q)
  );

  dmem_arbiter_register #(.W(1)) u_valid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (rd_gnt),
    .q     (valid_q)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MW = 4;
  localparam int BM = 8;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_read, cpu_write, cpu_stall;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_read, mem_write;
  logic [CW-1:0] stall_count;
  logic          load_mem;

  always #5 clk = ~clk;

  dmem_arbiter_if ext_bus ();

  dmem_arbiter #(.MAX_WAIT(MW), .BURST_MAX(BM), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .ext         (ext_bus),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata),
    .stall_count (stall_count)
  );

  // Environment data memory, combinational read, written from the DUT's mem port.
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  assign mem_rdata = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
    end else if (mem_write) begin
      env_mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Reference model state, phrased as the arbitration rules describe it.
  int          refused;
  int          locked_run;
  logic        m_valid;
  logic [31:0] m_rdata;
  int          m_stalls;
  int          tests;
  int          fails;
  logic        d_gnt, d_stall;
  logic        last_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] waddr(input logic [7:0] idx);
    return 32'h1000_0000 | {22'd0, idx, 2'b00};
  endfunction

  task automatic model_reset();
    refused    = 0;
    locked_run = 0;
    m_valid    = 1'b0;
    m_rdata    = 32'd0;
    m_stalls   = 0;
  endtask

  task automatic step();
    logic        acc, eg, es, er, ew;
    logic [31:0] ea, ewd;
    @(negedge clk);
    acc = cpu_read | cpu_write;
    if (!ext_bus.req || locked_run == BM) eg = 1'b0;
    else if (!acc)                        eg = 1'b1;
    else                                  eg = (refused == MW);
    es  = acc & eg;
    ea  = eg ? ext_bus.addr  : cpu_addr;
    ewd = eg ? ext_bus.wdata : cpu_wdata;
    er  = eg ? ~ext_bus.we   : cpu_read;
    ew  = eg ? ext_bus.we    : cpu_write;

    chk("ext_gnt",     32'(ext_bus.gnt),   32'(eg));
    chk("cpu_stall",   32'(cpu_stall),     32'(es));
    chk("mem_addr",    mem_addr,           ea);
    chk("mem_wdata",   mem_wdata,          ewd);
    chk("mem_read",    32'(mem_read),      32'(er));
    chk("mem_write",   32'(mem_write),     32'(ew));
    chk("cpu_rdata",   cpu_rdata,          ref_mem[ea[9:2]]);
    chk("ext_valid",   32'(ext_bus.valid), 32'(m_valid));
    chk("ext_rdata",   ext_bus.rdata,      m_rdata);
    chk("stall_count", 32'(stall_count),   32'(m_stalls));
    d_gnt    = ext_bus.gnt;
    d_stall  = cpu_stall;
    last_gnt = eg;

    if (eg && !ext_bus.we) begin
      m_valid = 1'b1;
      m_rdata = ref_mem[ea[9:2]];
    end else begin
      m_valid = 1'b0;
    end
    if (ew) ref_mem[ea[9:2]] = ewd;
    if (es && m_stalls < SAT) m_stalls++;
    if (ext_bus.req && !eg) refused = (refused < MW) ? refused + 1 : MW;
    else                    refused = 0;
    if (!ext_bus.req || locked_run == BM) locked_run = 0;
    else if (eg)                          locked_run = ext_bus.lock ? locked_run + 1 : 0;

    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [7:0] idx, input logic [31:0] wd);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = waddr(idx);
    cpu_wdata = wd;
  endtask

  task automatic set_ext(input logic rq, input logic we, input logic lk, input logic [7:0] idx, input logic [31:0] wd);
    ext_bus.req   = rq;
    ext_bus.we    = we;
    ext_bus.lock  = lk;
    ext_bus.addr  = waddr(idx);
    ext_bus.wdata = wd;
  endtask

  initial begin
    logic [9:0] pat;
    logic       pending;
    int         bad;
    int         r;
    tests = 0;
    fails = 0;
    model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEAD_BEEF;
    set_cpu(1'b0, 1'b0, 8'd0, 32'd0);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    reset    = 1'b1;
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    load_mem = 1'b0;

    chk("rst_valid", 32'(ext_bus.valid), 32'd0);
    chk("rst_rdata", ext_bus.rdata, 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);

    // CPU idle, external read of 0x10000010.
    set_ext(1'b1, 1'b0, 1'b0, 8'd4, 32'd0);
    step();
    chk("t1_gnt", 32'(d_gnt), 32'd1);
    chk("t1_stall", 32'(d_stall), 32'd0);
    chk("t1_valid", 32'(ext_bus.valid), 32'd1);
    chk("t1_rdata", ext_bus.rdata, 32'hDEAD_BEEF);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    step();

    // CPU loads every cycle; held external write is forced through on the 5th cycle.
    set_cpu(1'b1, 1'b0, 8'd7, 32'd0);
    set_ext(1'b1, 1'b1, 1'b0, 8'd20, 32'h1234_5678);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      pat[i] = d_gnt;
      if (i == 4) chk("t2_stall", 32'(d_stall), 32'd1);
    end
    chk("t2_gnt_pattern", 32'(pat), 32'b10000);
    chk("t2_mem", env_mem[20], 32'h1234_5678);
    chk("t2_stall_count", 32'(stall_count), 32'd1);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    step();

    // CPU store collides with a fresh external request: CPU wins, no stall.
    set_cpu(1'b0, 1'b1, 8'd30, 32'hA5A5_5A5A);
    set_ext(1'b1, 1'b0, 1'b0, 8'd31, 32'd0);
    step();
    chk("t3_gnt", 32'(d_gnt), 32'd0);
    chk("t3_stall", 32'(d_stall), 32'd0);
    chk("t3_mem", env_mem[30], 32'hA5A5_5A5A);
    set_cpu(1'b1, 1'b0, 8'd9, 32'd0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      pat[i] = d_gnt;
    end
    chk("t3_forced_after_one_wait", 32'(pat), 32'b1000);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    set_cpu(1'b0, 1'b0, 8'd0, 32'd0);
    step();

    // Locked burst with the CPU idle: 8 grants, one CPU cycle, then grant again.
    set_ext(1'b1, 1'b0, 1'b1, 8'd40, 32'd0);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      pat[i] = d_gnt;
      ext_bus.addr = waddr(8'(41 + i));
    end
    chk("t4_burst_pattern", 32'(pat), 32'b10_1111_1111);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    step();

    // Reset with three refusals accumulated discards the wait history.
    set_cpu(1'b1, 1'b0, 8'd11, 32'd0);
    set_ext(1'b1, 1'b1, 1'b0, 8'd50, 32'hCAFE_F00D);
    repeat (3) step();
    set_cpu(1'b0, 1'b0, 8'd0, 32'd0);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("t5_valid", 32'(ext_bus.valid), 32'd0);
    chk("t5_stall_count", 32'(stall_count), 32'd0);
    set_cpu(1'b1, 1'b0, 8'd11, 32'd0);
    set_ext(1'b1, 1'b1, 1'b0, 8'd50, 32'hCAFE_F00D);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      pat[i] = d_gnt;
    end
    chk("t5_cpu_wins_after_reset", 32'(pat), 32'b10000);

    // Repeated forced grants push the 4-bit stall counter into saturation.
    for (int g = 0; g < 18; g++) begin
      set_ext(1'b1, 1'b1, 1'b0, 8'(60 + g), $urandom);
      repeat (5) step();
    end
    chk("t6_stall_sat", 32'(stall_count), 32'd15);
    repeat (5) step();
    chk("t6_stall_hold", 32'(stall_count), 32'd15);

    // Randomized traffic; an external request holds its fields until granted.
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 8'd0, 32'd0);
    set_ext(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      set_cpu(1'b1, 1'b0, 8'($urandom), 32'd0);
      else if (r < 7) set_cpu(1'b0, 1'b1, 8'($urandom), $urandom);
      else            set_cpu(1'b0, 1'b0, 8'($urandom), $urandom);
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          set_ext(1'b1, 1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), $urandom);
          pending = 1'b1;
        end else begin
          set_ext(1'b0, 1'b0, 1'b0, 8'($urandom), $urandom);
        end
      end
      step();
      if (last_gnt) pending = 1'b0;
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_words_differing", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
